trace_event_player: RTL and testbench
=====================================

Name: trace_event_player

Overview:
- Synthesizable, parametrised stimulus source for RTLola monitor top entities. Replaces hand-written delay/pulse sequences in end-to-end benches.
- Replays a table of timestamped input events into the monitor's input_k / new_input_k pins. Each event drives a one-cycle new_input pulse with values.
- Supports N input streams, arbitrary data width, per-event channel masks, enable-gated time, and one-shot or looping playback.
- Sits between bench/host loader and monitor; shares clk, rst, en with the monitor.

Parameters:
- NUM_INPUTS, 1, number of monitor input streams driven.
- DATA_W, 64, width of each input value (signed two's complement, passed through unchanged).
- DEPTH, 16, number of event records in the table.
- DELAY_W, 16, width of the per-event delay field in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  time enable; shared with monitor.
- wr_en  in  1  table write strobe.
- wr_addr  in  clog2(DEPTH)  record index.
- wr_delay  in  DELAY_W  idle cycles before this event.
- wr_mask  in  NUM_INPUTS  streams fired by this event.
- wr_data  in  NUM_INPUTS*DATA_W  values, stream k at bits [k*DATA_W +: DATA_W].
- num_events  in  clog2(DEPTH)+1  records to play, 0..DEPTH.
- loop_en  in  1  restart at record 0 after the last record.
- start  in  1  begin playback (pulse).
- abort  in  1  stop playback (pulse).
- input_val  out  NUM_INPUTS*DATA_W  value bus to monitor.
- new_input  out  NUM_INPUTS  per-stream event strobe.
- busy  out  1  playback in progress.
- done  out  1  one-shot playback finished; sticky.
- event_idx  out  clog2(DEPTH)  index of current/next record.
- wr_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (rst=0, async): state IDLE. input_val=0, new_input=0, busy=0, done=0, event_idx=0, wr_err=0, delay counter=0. Table contents are not reset.
- Table: register array with combinational read at event_idx. A write takes effect at the clock edge when wr_en=1 in IDLE or DONE.
  - wr_en while busy: write dropped, wr_err=1 next cycle.
  - wr_addr >= DEPTH: write dropped, wr_err=1 next cycle.
- All outputs are registered.
- States: IDLE, WAIT, FIRE, DONE.
  - IDLE/DONE with start=1:
    - If num_events=0: go to DONE, done=1, busy=0.
    - Otherwise: event_idx=0, cnt=delay[0], go to WAIT, busy=1, done=0.
  - WAIT, en=1:
    - cnt>0: cnt decrements.
    - cnt=0: go to FIRE.
  - WAIT, en=0: hold; counter frozen.
  - FIRE (exactly one cycle): new_input=mask[idx], input_val=data[idx] on masked lanes, 0 on unmasked lanes. Then:
    - idx < num_events-1: idx+1, reload cnt=delay[idx+1], go to WAIT.
    - Last record, loop_en=1: idx=0, cnt=delay[0], go to WAIT.
    - Last record, loop_en=0: go to DONE, busy=0, done=1.
- Timing contract: with en held at 1 and start sampled at edge T, record 0 is visible on outputs in the cycle after edge T+1+delay[0]. Record k fires delay[k]+1 cycles after record k-1. Delay 0 gives back-to-back pulses.
- Outside FIRE, new_input=0 and input_val=0.
- en low: stretches WAIT only. FIRE is entered only on an edge with en=1.
- start while busy: ignored.
- abort: highest priority; wins over simultaneous start. Go to IDLE next edge; clear outputs, busy, done.
- loop_en is sampled at each last-record FIRE, so changing it mid-run takes effect at the next wrap.
- num_events > DEPTH: clamped to DEPTH.
- mask=0 record: consumes time; no strobe.

Decomposition:
- trace_player_pkg: state encoding, record field offsets and REC_W = DELAY_W+NUM_INPUTS+NUM_INPUTS*DATA_W, clog2 helper.
- Sub-module trace_event_mem: DEPTH x REC_W register array, one write port, one combinational read port.

Test Plan:
1. NUM_INPUTS=1, records (delay 499, value 1), (149, 2), (49, 3); en=1; start at cycle 10 -> new_input pulses at cycles 511, 661, 711; input_val = 1, 2, 3 only in those cycles; done=1 from 712.
2. NUM_INPUTS=2, DATA_W=8, record mask=2'b10, data {8'h85, 8'h22}, delay 0 -> one-cycle pulse new_input=2'b10, input_val lane1=-123, lane0=0; next record delay 0 fires the following cycle.
3. Two records with delay 3, loop_en=1 -> pulse every 4 cycles, event_idx toggles 0,1,0,1. Clear loop_en -> stops after the next idx-1 fire with done=1.
4. en low for 10 cycles during WAIT with delay 20 -> fire delayed by exactly 10 cycles; en=0 at counter expiry -> no pulse until en returns.
5. abort and start in the same cycle mid-WAIT -> IDLE, busy=0, no further pulses. wr_en while busy -> wr_err pulse, table unchanged.
6. Assert rst during FIRE -> new_input and input_val zero immediately (asynchronously). num_events=0 start -> done=1 one cycle later, no pulses.

Source files
------------

// File: rtl/trace_event_player_pkg.sv
// Shared types and helpers for the trace event player: FSM encoding,
// record layout offsets and width helpers.
package trace_event_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FIRE,
        ST_DONE
    } state_e;

    // Address width, never below one bit so DEPTH=1 still elaborates.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w = w + 1;
        return w;
    endfunction

    // Record layout, LSB first: {data, mask, delay}.
    function automatic int rec_w(input int num_inputs, input int data_w, input int delay_w);
        return delay_w + num_inputs + num_inputs * data_w;
    endfunction

    function automatic int mask_lsb(input int delay_w);
        return delay_w;
    endfunction

    function automatic int data_lsb(input int num_inputs, input int delay_w);
        return delay_w + num_inputs;
    endfunction

endpackage

// File: rtl/trace_event_player_if.sv
// Host-side bus of the trace event player: table load, playback control
// and the value/strobe outputs toward the monitor.
interface trace_event_player_if
    import trace_event_player_pkg::*;
#(
    parameter int NUM_INPUTS = 1,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16,
    parameter int DELAY_W    = 16
);
    localparam int AW = clog2(DEPTH);

    logic                         wr_en;
    logic [AW-1:0]                wr_addr;
    logic [DELAY_W-1:0]           wr_delay;
    logic [NUM_INPUTS-1:0]        wr_mask;
    logic [NUM_INPUTS*DATA_W-1:0] wr_data;
    logic [AW:0]                  num_events;
    logic                         loop_en;
    logic                         start;
    logic                         abort;
    logic [NUM_INPUTS*DATA_W-1:0] input_val;
    logic [NUM_INPUTS-1:0]        new_input;
    logic                         busy;
    logic                         done;
    logic [AW-1:0]                event_idx;
    logic                         wr_err;

    modport master (
        output wr_en, wr_addr, wr_delay, wr_mask, wr_data,
        output num_events, loop_en, start, abort,
        input  input_val, new_input, busy, done, event_idx, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_delay, wr_mask, wr_data,
        input  num_events, loop_en, start, abort,
        output input_val, new_input, busy, done, event_idx, wr_err
    );

endinterface

// File: rtl/trace_event_player_mem.sv
// Event record table: one synchronous write port, one combinational read
// port. Contents are deliberately not reset.
module trace_event_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int REC_W = 81
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [REC_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [REC_W-1:0] rdata_o
);

    logic [REC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_event_player.sv
// Replays timestamped event records as one-cycle new_input pulses with
// per-lane values, gated by the shared time enable.
module trace_event_player
    import trace_event_player_pkg::*;
#(
    parameter int NUM_INPUTS = 1,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16,
    parameter int DELAY_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    trace_event_player_if.slave  bus
);

    localparam int AW       = clog2(DEPTH);
    localparam int VW       = NUM_INPUTS * DATA_W;
    localparam int REC_W    = rec_w(NUM_INPUTS, DATA_W, DELAY_W);
    localparam int MASK_LSB = mask_lsb(DELAY_W);
    localparam int DATA_LSB = data_lsb(NUM_INPUTS, DELAY_W);
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    state_e                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [DELAY_W-1:0]    cnt_q, cnt_d;
    logic [VW-1:0]         val_q, val_d;
    logic [NUM_INPUTS-1:0] new_q, new_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_err_q, wr_err_d;

    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         idx_next;
    logic [REC_W-1:0]      rec;
    logic [DELAY_W-1:0]    rec_delay;
    logic [NUM_INPUTS-1:0] rec_mask;
    logic [VW-1:0]         rec_data;
    logic [AW:0]           num_clamped;
    logic                  last_rec;
    logic                  wr_ok;

    function automatic logic [VW-1:0] lane_gate(input logic [VW-1:0]         data,
                                                input logic [NUM_INPUTS-1:0] mask);
        logic [VW-1:0]            res;
        logic signed [DATA_W-1:0] lane;
        res = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            lane = data[k*DATA_W +: DATA_W];
            if (mask[k]) res[k*DATA_W +: DATA_W] = lane;
        end
        return res;
    endfunction

    assign num_clamped = (32'(bus.num_events) > DEPTH) ? DEPTH_N : bus.num_events;
    assign last_rec    = ({1'b0, idx_q} == num_clamped - 1'b1);
    assign idx_next    = idx_q + 1'b1;
    assign wr_ok       = bus.wr_en && (state_q == ST_IDLE || state_q == ST_DONE)
                         && (32'(bus.wr_addr) < DEPTH);

    // In FIRE the table already points at the following record so a
    // zero-delay successor can fire on the very next edge.
    always_comb begin
        rd_addr = '0;
        if (state_q == ST_WAIT) rd_addr = idx_q;
        else if (state_q == ST_FIRE) rd_addr = last_rec ? '0 : idx_next;
    end

    trace_event_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .REC_W (REC_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (bus.wr_addr),
        .wdata_i ({bus.wr_data, bus.wr_mask, bus.wr_delay}),
        .raddr_i (rd_addr),
        .rdata_o (rec)
    );

    assign rec_delay = rec[DELAY_W-1:0];
    assign rec_mask  = rec[MASK_LSB +: NUM_INPUTS];
    assign rec_data  = rec[DATA_LSB +: VW];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        val_d    = '0;
        new_d    = '0;
        busy_d   = busy_q;
        done_d   = done_q;
        wr_err_d = bus.wr_en && !wr_ok;
        if (bus.abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        idx_d = '0;
                        if (num_clamped == '0) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = rec_delay;
                            busy_d  = 1'b1;
                            done_d  = 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (en_i) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            state_d = ST_FIRE;
                            new_d   = rec_mask;
                            val_d   = lane_gate(rec_data, rec_mask);
                        end
                    end
                end
                ST_FIRE: begin
                    if (last_rec && !bus.loop_en) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = last_rec ? '0 : idx_next;
                        // The edge leaving FIRE already counts toward the next
                        // delay, but only when time is enabled on it.
                        if (!en_i) begin
                            state_d = ST_WAIT;
                            cnt_d   = rec_delay;
                        end else if (rec_delay == '0) begin
                            state_d = ST_FIRE;
                            new_d   = rec_mask;
                            val_d   = lane_gate(rec_data, rec_mask);
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = rec_delay - 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            val_q    <= '0;
            new_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            new_q    <= new_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign bus.input_val = val_q;
    assign bus.new_input = new_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.event_idx = idx_q;
    assign bus.wr_err    = wr_err_q;

endmodule

// File: tb/tb_trace_event_player.sv
// Bench for trace_event_player: directed timing scenarios plus randomized
// playback, all checked every cycle against an event-schedule model.
module tb_trace_event_player;
    import trace_event_player_pkg::*;

    localparam int NI    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int DLW   = 10;
    localparam int AW    = clog2(DEPTH);
    localparam int VW    = NI * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    trace_event_player_if #(.NUM_INPUTS(NI), .DATA_W(DW), .DEPTH(DEPTH), .DELAY_W(DLW)) bus ();

    trace_event_player #(.NUM_INPUTS(NI), .DATA_W(DW), .DEPTH(DEPTH), .DELAY_W(DLW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference table and schedule state: a record fires on the
    // (delay+1)-th enabled edge after the previous fire or the start.
    logic [DLW-1:0] t_delay [DEPTH];
    logic [NI-1:0]  t_mask  [DEPTH];
    logic [VW-1:0]  t_data  [DEPTH];
    bit             playing = 0;
    bit             post_fire = 0;
    int             k = 0;
    int             need = 0;
    logic [NI-1:0]  m_new = '0;
    logic [VW-1:0]  m_val = '0;
    bit             m_busy = 0, m_done = 0, m_err = 0;
    int             m_idx = 0;

    int             fires[$];
    int             fire_idx[$];
    logic [VW-1:0]  fire_val[$];

    function automatic logic [VW-1:0] expect_val(input logic [NI-1:0] m, input logic [VW-1:0] d);
        logic [VW-1:0] r;
        r = '0;
        for (int l = 0; l < NI; l++) if (m[l]) r[l*DW +: DW] = d[l*DW +: DW];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        playing = 0; post_fire = 0; m_new = '0; m_val = '0;
        m_busy = 0; m_done = 0; m_err = 0; m_idx = 0;
    endtask

    task automatic model_edge();
        bit was_playing;
        int n;
        was_playing = playing;
        n = (int'(bus.num_events) > DEPTH) ? DEPTH : int'(bus.num_events);
        m_new = '0; m_val = '0; m_err = 0;
        if (bus.abort) begin
            playing = 0; post_fire = 0; m_busy = 0; m_done = 0; m_idx = 0;
        end else if (!playing) begin
            if (bus.start) begin
                m_idx = 0;
                if (n == 0) begin
                    m_done = 1; m_busy = 0;
                end else begin
                    playing = 1; post_fire = 0; k = 0;
                    need = int'(t_delay[0]) + 1; m_busy = 1; m_done = 0;
                end
            end
        end else begin
            if (post_fire) begin
                post_fire = 0;
                if (k == n - 1 && !bus.loop_en) begin
                    playing = 0; m_busy = 0; m_done = 1;
                end else begin
                    k = (k == n - 1) ? 0 : k + 1;
                    need = int'(t_delay[k]) + 1;
                    m_idx = k;
                end
            end
            if (playing) begin
                if (en) need--;
                if (need == 0) begin
                    m_new = t_mask[k];
                    m_val = expect_val(t_mask[k], t_data[k]);
                    post_fire = 1;
                end
            end
        end
        if (bus.wr_en) begin
            if (!was_playing && int'(bus.wr_addr) < DEPTH) begin
                t_delay[bus.wr_addr] = bus.wr_delay;
                t_mask[bus.wr_addr]  = bus.wr_mask;
                t_data[bus.wr_addr]  = bus.wr_data;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("new_input", 64'(bus.new_input), 64'(m_new));
        chk("input_val", 64'(bus.input_val), 64'(m_val));
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("done", 64'(bus.done), 64'(m_done));
        chk("event_idx", 64'(bus.event_idx), 64'(m_idx));
        chk("wr_err", 64'(bus.wr_err), 64'(m_err));
        if (bus.new_input != '0) begin
            fires.push_back(cyc);
            fire_idx.push_back(int'(bus.event_idx));
            fire_val.push_back(bus.input_val);
        end
        bus.start = 0; bus.abort = 0; bus.wr_en = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int a, input int d, input logic [NI-1:0] m, input logic [VW-1:0] v);
        bus.wr_en = 1; bus.wr_addr = AW'(a); bus.wr_delay = DLW'(d);
        bus.wr_mask = m; bus.wr_data = v;
        step();
    endtask

    task automatic clear_log();
        fires.delete(); fire_idx.delete(); fire_val.delete();
    endtask

    task automatic pad_log(input int n);
        while (fires.size() < n) begin
            fires.push_back(-100000); fire_idx.push_back(-1); fire_val.push_back('x);
        end
    endtask

    initial begin
        int t0;
        logic signed [DW-1:0] lane1;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_delay = '0; bus.wr_mask = '0; bus.wr_data = '0;
        bus.num_events = '0; bus.loop_en = 0; bus.start = 0; bus.abort = 0;
        #2;
        chk("rst_new_input", 64'(bus.new_input), 64'd0);
        chk("rst_input_val", 64'(bus.input_val), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_event_idx", 64'(bus.event_idx), 64'd0);
        chk("rst_wr_err", 64'(bus.wr_err), 64'd0);
        #10 rst_n = 1;
        en = 1;
        run(2);

        // Long delays: 499/149/49 on lane 0.
        wr(0, 499, 2'b01, 16'h0001);
        wr(1, 149, 2'b01, 16'h0002);
        wr(2, 49, 2'b01, 16'h0003);
        bus.num_events = 4'd3;
        clear_log();
        t0 = cyc + 1;
        bus.start = 1;
        run(710);
        pad_log(3);
        chk("p1_first", 64'(fires[0] - t0), 64'd500);
        chk("p1_gap1", 64'(fires[1] - fires[0]), 64'd150);
        chk("p1_gap2", 64'(fires[2] - fires[1]), 64'd50);
        chk("p1_val2", 64'(fire_val[2]), 64'h0003);
        chk("p1_done", 64'(bus.done), 64'd1);

        // Lane masking with signed data, back-to-back zero delays.
        wr(0, 0, 2'b10, {8'h85, 8'h22});
        wr(1, 0, 2'b01, {8'h11, 8'h44});
        bus.num_events = 4'd2;
        bus.start = 1;
        step();
        for (int i = 0; i < 10 && bus.new_input == '0; i++) step();
        lane1 = bus.input_val[15:8];
        chk("p2_mask", 64'(bus.new_input), 64'(2'b10));
        chk("p2_lane1", 64'(int'(lane1)), 64'(-123));
        chk("p2_lane0", 64'(bus.input_val[7:0]), 64'd0);
        step();
        chk("p2_next", 64'(bus.new_input), 64'(2'b01));
        chk("p2_next_val", 64'(bus.input_val), 64'h0044);
        run(3);

        // Looping two records with delay 3, then stop at the next wrap.
        wr(0, 3, 2'b01, 16'h0010);
        wr(1, 3, 2'b10, 16'h2000);
        bus.loop_en = 1;
        clear_log();
        t0 = cyc + 1;
        bus.start = 1;
        step();
        for (int i = 0; i < 30 && fires.size() < 3; i++) step();
        bus.loop_en = 0;
        run(15);
        chk("p3_count", 64'(fires.size()), 64'd4);
        pad_log(4);
        chk("p3_first", 64'(fires[0] - t0), 64'd4);
        for (int i = 0; i < 3; i++) chk("p3_gap", 64'(fires[i+1] - fires[i]), 64'd4);
        for (int i = 0; i < 4; i++) chk("p3_idx", 64'(fire_idx[i]), 64'(i % 2));
        chk("p3_done", 64'(bus.done), 64'd1);

        // Enable gating: 10 low cycles in WAIT, then low at expiry.
        wr(0, 20, 2'b01, 16'h0007);
        bus.num_events = 4'd1;
        clear_log();
        t0 = cyc + 1;
        bus.start = 1;
        step();
        run(4);
        en = 0; run(10);
        en = 1;
        for (int i = 0; i < 40 && fires.size() == 0; i++) step();
        pad_log(1);
        chk("p4_stretch", 64'(fires[0] - t0), 64'd31);
        run(3);
        clear_log();
        t0 = cyc + 1;
        bus.start = 1;
        step();
        run(20);
        en = 0; run(5);
        chk("p4_hold", 64'(fires.size()), 64'd0);
        en = 1; run(3);
        pad_log(1);
        chk("p4_release", 64'(fires[0] - t0), 64'd26);

        // Abort beats start; writes while busy are rejected.
        wr(0, 50, 2'b01, 16'h005A);
        clear_log();
        bus.start = 1;
        step();
        run(5);
        bus.abort = 1; bus.start = 1;
        step();
        chk("p5_abort_busy", 64'(bus.busy), 64'd0);
        run(60);
        chk("p5_no_fire", 64'(fires.size()), 64'd0);
        t0 = cyc + 1;
        bus.start = 1;
        step();
        run(3);
        wr(0, 2, 2'b11, 16'hFFFF);
        chk("p5_wr_err", 64'(bus.wr_err), 64'd1);
        for (int i = 0; i < 60 && fires.size() == 0; i++) step();
        pad_log(1);
        chk("p5_time", 64'(fires[0] - t0), 64'd51);
        chk("p5_val", 64'(fire_val[0]), 64'h005A);
        run(2);

        // Async reset during FIRE, then an empty playback.
        wr(0, 0, 2'b11, 16'hA5C3);
        bus.start = 1;
        step();
        step();
        chk("p6_fire", 64'(bus.new_input), 64'(2'b11));
        #2 rst_n = 0;
        #1;
        chk("p6_rst_new", 64'(bus.new_input), 64'd0);
        chk("p6_rst_val", 64'(bus.input_val), 64'd0);
        chk("p6_rst_busy", 64'(bus.busy), 64'd0);
        model_reset();
        #1 rst_n = 1;
        bus.num_events = 4'd0;
        clear_log();
        bus.start = 1;
        step();
        chk("p6_empty_done", 64'(bus.done), 64'd1);
        run(5);
        chk("p6_empty_fires", 64'(fires.size()), 64'd0);

        // Randomized playback against the model.
        for (int a = 0; a < DEPTH; a++)
            wr(a, $urandom_range(0, 7), NI'($urandom), VW'($urandom));
        for (int it = 0; it < 12; it++) begin
            bus.abort = 1;
            step();
            bus.num_events = 4'($urandom_range(0, 9));
            bus.loop_en = 1'($urandom);
            bus.start = 1;
            for (int c = 0; c < 60; c++) begin
                en = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 19) == 0) bus.loop_en = ~bus.loop_en;
                if ($urandom_range(0, 49) == 0) bus.abort = 1;
                if ($urandom_range(0, 29) == 0) bus.start = 1;
                if ($urandom_range(0, 14) == 0) begin
                    bus.wr_en = 1; bus.wr_addr = AW'($urandom_range(0, 7));
                    bus.wr_delay = DLW'($urandom_range(0, 5));
                    bus.wr_mask = NI'($urandom); bus.wr_data = VW'($urandom);
                end
                step();
            end
        end
        en = 1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
